// File: rtl/imm_narrow_pkg.sv
// imm_narrow_pkg: shared defaults, FIFO state type and saturation constants
// for the immediate narrowing block.
//   IMM_W_DEF / DATA_W_DEF / CNT_W_DEF : default widths
//   fifo_state_t                       : occupancy of the 2-entry output FIFO
//   IMM_MAX / IMM_MIN                  : saturation limits at the default IMM_W
package imm_narrow_pkg;

  localparam int IMM_W_DEF  = 14;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  localparam logic [IMM_W_DEF-1:0] IMM_MAX = 14'h1FFF;
  localparam logic [IMM_W_DEF-1:0] IMM_MIN = 14'h2000;

endpackage

// File: rtl/imm_narrow_core.sv
// imm_narrow_core: combinational narrowing of a two's-complement value to
// IMM_W bits, with overflow detection and optional saturation.
//   data   : wide input value (DATA_W)
//   sat_en : 1 = saturate on overflow, 0 = truncate
//   imm    : narrowed immediate (IMM_W)
//   ovf    : source value does not fit in IMM_W bits
module imm_narrow_core
  import imm_narrow_pkg::*;
#(
  parameter int IMM_W  = IMM_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data,
  input  logic              sat_en,
  output logic [IMM_W-1:0]  imm,
  output logic              ovf
);

  // Generic limits; at the default width these equal IMM_MAX / IMM_MIN.
  localparam logic [IMM_W-1:0] SAT_MAX = {1'b0, {(IMM_W-1){1'b1}}};
  localparam logic [IMM_W-1:0] SAT_MIN = {1'b1, {(IMM_W-1){1'b0}}};

  logic [DATA_W-IMM_W:0] upper;

  always_comb begin
    // The value fits iff every bit from the new sign position upward matches.
    upper = data[DATA_W-1:IMM_W-1];
    ovf   = !((&upper) || !(|upper));
    imm   = data[IMM_W-1:0];
    if (ovf && sat_en) begin
      imm = data[DATA_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/imm_narrow.sv
// imm_narrow: narrows a stream of DATA_W two's-complement words to IMM_W-bit
// immediates through a 2-entry valid/ready FIFO and counts overflowing words.
//   clk_i, rst_n              : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o     : input handshake, in_data_i + sat_en_i payload
//   out_valid_o/out_ready_i   : output handshake, out_imm_o + out_ovf_o payload
//   ovf_cnt_o, cnt_clr_i      : saturating overflow counter and its sync clear
module imm_narrow
  import imm_narrow_pkg::*;
#(
  parameter int IMM_W  = IMM_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              sat_en_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [IMM_W-1:0]  out_imm_o,
  output logic              out_ovf_o,
  output logic [CNT_W-1:0]  ovf_cnt_o,
  input  logic              cnt_clr_i
);

  fifo_state_t      state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic [IMM_W-1:0] head_imm_q, head_imm_d, tail_imm_q, tail_imm_d;
  logic             head_ovf_q, head_ovf_d, tail_ovf_q, tail_ovf_d;
  logic [CNT_W-1:0] cnt_q;

  logic [IMM_W-1:0] new_imm;
  logic             new_ovf;
  logic             push, pop;

  imm_narrow_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_core (
    .data   (in_data_i),
    .sat_en (sat_en_i),
    .imm    (new_imm),
    .ovf    (new_ovf)
  );

  assign push = in_valid_i & in_ready_q;
  assign pop  = out_valid_q & out_ready_i;

  // Head is the word on out_*, tail is the second slot used only when FULL.
  always_comb begin
    state_d    = state_q;
    head_imm_d = head_imm_q;
    head_ovf_d = head_ovf_q;
    tail_imm_d = tail_imm_q;
    tail_ovf_d = tail_ovf_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d    = ONE;
          head_imm_d = new_imm;
          head_ovf_d = new_ovf;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_imm_d = new_imm;
          head_ovf_d = new_ovf;
        end else if (push) begin
          state_d    = FULL;
          tail_imm_d = new_imm;
          tail_ovf_d = new_ovf;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d    = ONE;
          head_imm_d = tail_imm_q;
          head_ovf_d = tail_ovf_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_imm_q  <= '0;
      head_ovf_q  <= 1'b0;
      tail_imm_q  <= '0;
      tail_ovf_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      head_imm_q  <= head_imm_d;
      head_ovf_q  <= head_ovf_d;
      tail_imm_q  <= tail_imm_d;
      tail_ovf_q  <= tail_ovf_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr_i) begin
      cnt_q <= '0;
    end else if (push && new_ovf && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_imm_o   = head_imm_q;
  assign out_ovf_o   = head_ovf_q;
  assign ovf_cnt_o   = cnt_q;

endmodule

// File: tb/tb_imm_narrow.sv
// tb_imm_narrow: table-driven, directed and randomized checks of imm_narrow
// against an arithmetic reference model with a queue-based FIFO.
module tb_imm_narrow;
  import imm_narrow_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        sat_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [13:0] out_imm;
  logic        out_ovf;
  logic [7:0]  ovf_cnt;
  logic        cnt_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [13:0] imm;
    logic        ovf;
  } ent_t;

  typedef struct {
    logic [15:0] data;
    logic        sat;
    logic [13:0] exp_imm;
    logic        exp_ovf;
    int          exp_cnt;
  } vec_t;

  ent_t mq[$];
  int   mcnt = 0;

  imm_narrow #(
    .IMM_W  (14),
    .DATA_W (16),
    .CNT_W  (8)
  ) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .sat_en_i    (sat_en),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_imm_o   (out_imm),
    .out_ovf_o   (out_ovf),
    .ovf_cnt_o   (ovf_cnt),
    .cnt_clr_i   (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Narrowing from the value's numeric range rather than its bit pattern.
  function automatic ent_t model_narrow(input logic [15:0] d, input logic s);
    int   v;
    ent_t e;
    v = int'($signed(d));
    e.ovf = (v > 8191) || (v < -8192);
    if (e.ovf && s) e.imm = (v > 0) ? IMM_MAX : IMM_MIN;
    else            e.imm = d[13:0];
    return e;
  endfunction

  task automatic compare_model();
    chk("out_valid", out_valid, mq.size() > 0);
    chk("in_ready", in_ready, mq.size() < 2);
    chk("ovf_cnt", ovf_cnt, mcnt);
    if (mq.size() > 0) begin
      chk("out_imm", out_imm, mq[0].imm);
      chk("out_ovf", out_ovf, mq[0].ovf);
    end
  endtask

  // One clock: decide transfers from the pre-edge model state, advance, compare.
  task automatic tick();
    bit   push, pop;
    ent_t e;
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() > 0);
    e    = model_narrow(in_data, sat_en);
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(e);
    if (cnt_clr) mcnt = 0;
    else if (push && e.ovf && mcnt < 255) mcnt = mcnt + 1;
    compare_model();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    repeat (3) tick();
  endtask

  vec_t        tbl[10];
  logic [13:0] held;
  logic [15:0] bnd[6];

  initial begin
    tbl[0] = '{16'h1FFF, 1'b1, 14'h1FFF, 1'b0, 0};
    tbl[1] = '{16'hE000, 1'b1, 14'h2000, 1'b0, 0};
    tbl[2] = '{16'h0005, 1'b1, 14'h0005, 1'b0, 0};
    tbl[3] = '{16'h4000, 1'b1, 14'h1FFF, 1'b1, 1};
    tbl[4] = '{16'h8000, 1'b0, 14'h0000, 1'b1, 2};
    tbl[5] = '{16'h7FFF, 1'b1, 14'h1FFF, 1'b1, 3};
    tbl[6] = '{16'h8000, 1'b1, 14'h2000, 1'b1, 4};
    tbl[7] = '{16'hFFFF, 1'b0, 14'h3FFF, 1'b0, 4};
    tbl[8] = '{16'h2000, 1'b0, 14'h2000, 1'b1, 5};
    tbl[9] = '{16'hDFFF, 1'b1, 14'h2000, 1'b1, 6};
    bnd = '{16'h1FFF, 16'h2000, 16'hE000, 16'hDFFF, 16'h7FFF, 16'h8000};

    // Reset state, before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_imm", out_imm, 14'h0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    chk("rst_cnt", ovf_cnt, 8'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Table: one word per cycle with out_ready=1, each visible one cycle later.
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[i].data;
      sat_en   = tbl[i].sat;
      tick();
      chk("tbl_valid", out_valid, 1'b1);
      chk("tbl_imm", out_imm, tbl[i].exp_imm);
      chk("tbl_ovf", out_ovf, tbl[i].exp_ovf);
      chk("tbl_cnt", ovf_cnt, tbl[i].exp_cnt);
    end
    drain();

    // Backpressure: three words offered, only two fit, head held stable.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sat_en    = 1'b0;
    in_data = 16'h0011; tick(); chk("bp_ready1", in_ready, 1'b1);
    held = out_imm;
    in_data = 16'h0022; tick(); chk("bp_ready2", in_ready, 1'b0);
    in_data = 16'h0033;
    repeat (3) begin
      tick();
      chk("bp_stable", out_imm, held);
      chk("bp_full", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick(); chk("bp_drain_b", out_imm, 14'h0022);
    tick(); chk("bp_drain_c", out_imm, 14'h0033);
    in_valid = 1'b0;
    tick(); chk("bp_empty", out_valid, 1'b0);

    // Steady state ONE: push and pop every cycle.
    in_valid = 1'b1;
    in_data = 16'h0100; tick();
    for (int unsigned i = 0; i < 8; i++) begin
      in_data = 16'(16'h0200 + i);
      tick();
      chk("one_valid", out_valid, 1'b1);
      chk("one_ready", in_ready, 1'b1);
      chk("one_imm", out_imm, 14'(14'h0200 + i));
    end
    drain();

    // Counter saturation and clear priority.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 255; i++) begin
      in_data = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
      sat_en  = 1'($urandom_range(0, 1));
      tick();
    end
    chk("cnt_255", ovf_cnt, 8'd255);
    in_data = 16'h9000; tick();
    chk("cnt_hold", ovf_cnt, 8'd255);
    cnt_clr = 1'b1; in_data = 16'h5000; tick();
    chk("cnt_clr_prio", ovf_cnt, 8'd0);
    cnt_clr = 1'b0;
    drain();

    // Asynchronous reset while FULL, asserted between edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 16'h7000; tick();
    in_data = 16'h0044; tick();
    chk("pre_rst_full", in_ready, 1'b0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    mq.delete();
    mcnt = 0;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_cnt", ovf_cnt, 8'd0);
    @(posedge clk);
    #1 chk("arst_hold", out_valid, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    in_valid = 1'b1; in_data = 16'h0055; sat_en = 1'b0;
    tick();
    chk("post_rst_imm", out_imm, 14'h0055);
    chk("post_rst_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    drain();

    // Randomized traffic against the model.
    for (int unsigned i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      sat_en    = 1'($urandom_range(0, 1));
      cnt_clr   = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 1) == 0) in_data = bnd[$urandom_range(0, 5)];
      else in_data = 16'($urandom);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
